// File: rtl/key_tone_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_tone_selector                                               |
// | Purpose  : Debounces the piano key switches and selects one key by fixed   |
// |            priority, with the lowest index winning. The selected note      |
// |            generator's square wave is routed to the single speaker pin.    |
// |            The route changes only while the outgoing tone is low, so no    |
// |            truncated high pulse reaches the speaker.                       |
// | Ports    : clk        - system clock                                        |
// |            reset      - asynchronous active-low reset                       |
// |            keys_raw   - raw key switches (1 = pressed), asynchronous       |
// |            tones      - 50% square waves, bit i is note i                   |
// |            speaker    - registered selected tone                            |
// |            note_on    - high while a tone is routed                         |
// |            active_key - index of the routed key                             |
// | Options  : define SUSTAIN_EN to add a RELEASE state. In that state the     |
// |            note keeps sounding for SUSTAIN_CYCLES after the key is let go.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_tone_selector #(
  parameter int NUM_KEYS        = 8,
  parameter int KEY_W           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
`ifdef SUSTAIN_EN
  ,
  parameter int SUSTAIN_CYCLES  = 12500000,
  parameter int SUS_W           = 24
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  input  logic [NUM_KEYS-1:0] tones,
  output logic                speaker,
  output logic                note_on,
  output logic [KEY_W-1:0]    active_key
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef SUSTAIN_EN
  localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'(SUSTAIN_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_WAIT_LOW = 2'd2
`ifdef SUSTAIN_EN
    ,
    S_RELEASE  = 2'd3
`endif
  } state_t;

  // Synchronizer and debounce storage
  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync_key;
  logic [NUM_KEYS-1:0] deb_key;
  logic [CNT_W-1:0]    deb_cnt [NUM_KEYS];

  // Request decode
  logic                req_valid;
  logic [KEY_W-1:0]    req_idx;
  logic                cur_tone;

  // FSM
  state_t              state;
  state_t              state_nxt;
  logic [KEY_W-1:0]    key_nxt;
  logic                note_nxt;
  logic                spk_nxt;
`ifdef SUSTAIN_EN
  logic [SUS_W-1:0]    sus_cnt;
`endif

  // Two-flop synchronizer on every key
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_key  <= '0;
    end else begin
      sync_meta <= keys_raw;
      sync_key  <= sync_meta;
    end
  end

  // Per-key debounce: a new level must persist DEBOUNCE_CYCLES consecutive
  // cycles. Any cycle where the synchronized key agrees with the accepted
  // level restarts the count, so bounces shorter than the window are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_key <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync_key[i] == deb_key[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_key[i] <= sync_key[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-index pressed key wins. The scan runs downward, so the last
  // hit is the lowest set bit.
  always_comb begin
    req_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (deb_key[i]) begin
        req_idx = KEY_W'(i);
      end
    end
  end

  assign req_valid = |deb_key;
  assign cur_tone  = tones[active_key];

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      active_key <= '0;
      note_on    <= 1'b0;
      speaker    <= 1'b0;
    end else begin
      state      <= state_nxt;
      active_key <= key_nxt;
      note_on    <= note_nxt;
      speaker    <= spk_nxt;
    end
  end

`ifdef SUSTAIN_EN
  // The counter is held at zero outside RELEASE, so it starts at zero on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sus_cnt <= '0;
    end else if (state != S_RELEASE) begin
      sus_cnt <= '0;
    end else begin
      sus_cnt <= sus_cnt + 1'b1;
    end
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    key_nxt   = active_key;
    note_nxt  = note_on;
    spk_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        note_nxt = 1'b0;
        if (req_valid) begin
          key_nxt   = req_idx;
          note_nxt  = 1'b1;
          state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        spk_nxt = cur_tone;
        if (!req_valid) begin
`ifdef SUSTAIN_EN
          state_nxt = S_RELEASE;
`else
          state_nxt = S_WAIT_LOW;
`endif
        end else if (req_idx != active_key) begin
          state_nxt = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        // Leave only while the outgoing tone is low. The speaker then
        // registers 0 here, so the next tone starts from a clean low level.
        spk_nxt = cur_tone;
        if (!cur_tone) begin
          if (req_valid) begin
            key_nxt   = req_idx;
            state_nxt = S_PLAY;
          end else begin
            note_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      end
`ifdef SUSTAIN_EN
      S_RELEASE: begin
        spk_nxt = cur_tone;
        if (req_valid) begin
          if (req_idx == active_key) begin
            state_nxt = S_PLAY;
          end else begin
            state_nxt = S_WAIT_LOW;
          end
        end else if (sus_cnt == SUS_LAST) begin
          state_nxt = S_WAIT_LOW;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
